// File: rtl/busca_sar_if.sv
// Bus between the SAR search engine and its host/comparator side: start/done
// handshake, comparator flags in, trial value and result out.
interface busca_sar_if #(
    parameter int unsigned WIDTH = 4
);
    logic             iniciar;
    logic             AmaiorB;
    logic             AmenorB;
    logic             AigualB;
    logic [WIDTH-1:0] B;
    logic             ocupado;
    logic             pronto;
    logic [WIDTH-1:0] resultado;
    logic             erro;

    // Host plus comparator side: issues start and returns the compare flags.
    modport master (
        output iniciar, AmaiorB, AmenorB, AigualB,
        input  B, ocupado, pronto, resultado, erro
    );

    // Search engine side.
    modport slave (
        input  iniciar, AmaiorB, AmenorB, AigualB,
        output B, ocupado, pronto, resultado, erro
    );
endinterface

// File: rtl/busca_sar.sv
// Successive-approximation search: binary-searches the unknown comparator A
// input by driving trial values on B, one compare per cycle.
module busca_sar #(
    parameter int unsigned WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    busca_sar_if.slave    bus
);
    localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IdxW-1:0]  IdxMax = IdxW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MsbOnly = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {StOcioso, StCompara, StFim} estado_t;

    estado_t          estadoQ, estadoD;
    logic [WIDTH-1:0] bQ, bD;
    logic [WIDTH-1:0] resultadoQ, resultadoD;
    logic [IdxW-1:0]  idxQ, idxD;
    logic             ocupadoQ, ocupadoD;
    logic             prontoQ, prontoD;
    logic             erroQ, erroD;

    logic [2:0]       flags;
    logic             flagsOk;
    logic [WIDTH-1:0] trial;

    assign flags   = {bus.AmaiorB, bus.AmenorB, bus.AigualB};
    assign flagsOk = flags inside {3'b001, 3'b010, 3'b100};

    always_comb begin
        estadoD    = estadoQ;
        bD         = bQ;
        resultadoD = resultadoQ;
        idxD       = idxQ;
        ocupadoD   = ocupadoQ;
        prontoD    = 1'b0;
        erroD      = erroQ;
        trial      = bQ;

        unique case (estadoQ)
            StOcioso: begin
                if (bus.iniciar) begin
                    bD         = MsbOnly;
                    idxD       = IdxMax;
                    erroD      = 1'b0;
                    resultadoD = '0;
                    ocupadoD   = 1'b1;
                    estadoD    = StCompara;
                end
            end
            StCompara: begin
                if (!flagsOk) begin
                    erroD      = 1'b1;
                    resultadoD = '0;
                    ocupadoD   = 1'b0;
                    prontoD    = 1'b1;
                    estadoD    = StFim;
                end else if (bus.AigualB) begin
                    resultadoD = bQ;
                    ocupadoD   = 1'b0;
                    prontoD    = 1'b1;
                    estadoD    = StFim;
                end else begin
                    // A below the trial: the bit under test cannot be part of A.
                    if (bus.AmenorB) begin
                        trial[idxQ] = 1'b0;
                    end
                    if (idxQ == '0) begin
                        bD         = trial;
                        resultadoD = trial;
                        ocupadoD   = 1'b0;
                        prontoD    = 1'b1;
                        estadoD    = StFim;
                    end else begin
                        trial[idxQ - 1'b1] = 1'b1;
                        bD                 = trial;
                        idxD               = idxQ - 1'b1;
                    end
                end
            end
            StFim: begin
                estadoD = StOcioso;
            end
            default: begin
                estadoD = StOcioso;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estadoQ    <= StOcioso;
            bQ         <= '0;
            resultadoQ <= '0;
            idxQ       <= IdxMax;
            ocupadoQ   <= 1'b0;
            prontoQ    <= 1'b0;
            erroQ      <= 1'b0;
        end else begin
            estadoQ    <= estadoD;
            bQ         <= bD;
            resultadoQ <= resultadoD;
            idxQ       <= idxD;
            ocupadoQ   <= ocupadoD;
            prontoQ    <= prontoD;
            erroQ      <= erroD;
        end
    end

    assign bus.B         = bQ;
    assign bus.resultado = resultadoQ;
    assign bus.ocupado   = ocupadoQ;
    assign bus.pronto    = prontoQ;
    assign bus.erro      = erroQ;
endmodule

// File: tb/tb_busca_sar.sv
// Bench for busca_sar: models the 4-bit comparator around a chosen A and checks
// trial sequence, latency, result and handshake against an arithmetic model.
module tb_busca_sar;
    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   aVal;
    bit   forceBad;
    int   passCnt;
    int   totalCnt;
    int   prontoCnt;

    busca_sar_if #(.WIDTH(W)) bus ();

    busca_sar #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Comparator model; forceBad makes the flags inconsistent (two set).
    assign bus.AmaiorB = forceBad || (aVal > int'(bus.B));
    assign bus.AmenorB = forceBad || (aVal < int'(bus.B));
    assign bus.AigualB = !forceBad && (aVal == int'(bus.B));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial prontoCnt = 0;
    always @(negedge clk) if (bus.pronto) prontoCnt++;

    typedef struct {
        int a;
        bit bad;
        int expRes;
        int expErr;
        int expN;
    } vec_t;

    vec_t tbl[6];

    // Compares needed: the search hits A once all bits down to its lowest set
    // bit have been decided; A=0 needs every bit.
    function automatic int modelN(int a);
        if (a == 0) return W;
        for (int b = 0; b < W; b++) begin
            if (((a >> b) & 1) == 1) return W - b;
        end
        return W;
    endfunction

    // k-th trial: A's bits above the bit under test, plus that bit set.
    function automatic int trialB(int a, int k);
        int pos;
        pos = W - k;
        return (a & ~((1 << (pos + 1)) - 1)) | (1 << pos);
    endfunction

    task automatic check(string name, int act, int exp);
        totalCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic runSearch(string tag, int a, bit bad, int expRes, int expErr,
                             int expN, int pulseAt);
        int n;
        bit seen;
        aVal          = a;
        forceBad      = bad;
        bus.iniciar   = 1'b1;
        @(posedge clk); #1;
        bus.iniciar   = 1'b0;
        check({tag, " ocupado after accept"}, int'(bus.ocupado), 1);
        check({tag, " erro cleared on accept"}, int'(bus.erro), 0);
        check({tag, " resultado cleared on accept"}, int'(bus.resultado), 0);
        n    = 0;
        seen = 0;
        for (int k = 1; k <= W + 2 && !seen; k++) begin
            if (k <= expN) check({tag, " trial B"}, int'(bus.B), trialB(a, k));
            if (k == pulseAt) bus.iniciar = 1'b1;
            @(posedge clk); #1;
            bus.iniciar = 1'b0;
            if (bus.pronto) begin
                seen = 1;
                n    = k;
            end
        end
        check({tag, " pronto seen"}, int'(seen), 1);
        check({tag, " compare count"}, n, expN);
        check({tag, " resultado"}, int'(bus.resultado), expRes);
        check({tag, " erro"}, int'(bus.erro), expErr);
        check({tag, " ocupado in FIM"}, int'(bus.ocupado), 0);
        forceBad = 0;
        @(posedge clk); #1;
        check({tag, " pronto single cycle"}, int'(bus.pronto), 0);
        check({tag, " resultado held"}, int'(bus.resultado), expRes);
    endtask

    initial begin
        int p0;
        int n;
        bit seen;
        passCnt     = 0;
        totalCnt    = 0;
        aVal        = 0;
        forceBad    = 0;
        bus.iniciar = 1'b0;
        rst_n       = 1'b0;

        tbl[0] = '{a: 9,  bad: 0, expRes: 9,  expErr: 0, expN: 4};
        tbl[1] = '{a: 8,  bad: 0, expRes: 8,  expErr: 0, expN: 1};
        tbl[2] = '{a: 0,  bad: 0, expRes: 0,  expErr: 0, expN: 4};
        tbl[3] = '{a: 15, bad: 0, expRes: 15, expErr: 0, expN: 4};
        tbl[4] = '{a: 7,  bad: 1, expRes: 0,  expErr: 1, expN: 1};
        tbl[5] = '{a: 5,  bad: 0, expRes: 5,  expErr: 0, expN: 4};

        repeat (2) @(posedge clk); #1;
        check("reset B", int'(bus.B), 0);
        check("reset resultado", int'(bus.resultado), 0);
        check("reset ocupado", int'(bus.ocupado), 0);
        check("reset pronto", int'(bus.pronto), 0);
        check("reset erro", int'(bus.erro), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            runSearch($sformatf("vec%0d", i), tbl[i].a, tbl[i].bad, tbl[i].expRes,
                      tbl[i].expErr, tbl[i].expN, 0);
            if (tbl[i].bad) check("erro held in idle", int'(bus.erro), 1);
        end

        // iniciar pulsed mid-search must not restart it.
        runSearch("pulse", 6, 0, 6, 0, modelN(6), 2);

        // Reset mid-search.
        aVal        = 3;
        bus.iniciar = 1'b1;
        @(posedge clk); #1;
        bus.iniciar = 1'b0;
        @(posedge clk); #1;
        p0    = prontoCnt;
        rst_n = 1'b0;
        #1;
        check("midrst B", int'(bus.B), 0);
        check("midrst ocupado", int'(bus.ocupado), 0);
        check("midrst pronto", int'(bus.pronto), 0);
        check("midrst resultado", int'(bus.resultado), 0);
        check("midrst erro", int'(bus.erro), 0);
        repeat (3) @(posedge clk); #1;
        check("midrst no pronto", prontoCnt - p0, 0);
        rst_n = 1'b1;
        runSearch("after reset", 5, 0, 5, 0, modelN(5), 0);

        // Exhaustive sweep with iniciar held high.
        p0          = prontoCnt;
        bus.iniciar = 1'b1;
        for (int a = 0; a < 16; a++) begin
            aVal = a;
            @(posedge clk); #1;
            check("sweep accepted", int'(bus.ocupado), 1);
            n    = 0;
            seen = 0;
            for (int k = 1; k <= W + 2 && !seen; k++) begin
                @(posedge clk); #1;
                if (bus.pronto) begin
                    seen = 1;
                    n    = k;
                end
            end
            check("sweep count", n, modelN(a));
            check("sweep resultado", int'(bus.resultado), a);
            if (a == 15) bus.iniciar = 1'b0;
            @(posedge clk); #1;
            check("sweep pronto low", int'(bus.pronto), 0);
        end
        bus.iniciar = 1'b0;
        check("sweep pronto count", prontoCnt - p0, 16);

        // Random values with random idle gaps.
        for (int r = 0; r < 24; r++) begin
            int a;
            a = int'($urandom_range(0, 15));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            runSearch($sformatf("rnd%0d", r), a, 0, a, 0, modelN(a), 0);
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
